btn_pulse_gen: RTL and testbench
================================

// Module: btn_pulse_gen
// PURPOSE
//  Conditions raw push-button inputs into clean single-cycle press pulses.
//  - Per channel: 2-flop synchronizer, counter-based debouncer, rising-press one-shot.
//  - Sits directly upstream of the LED pong game FSM and drives its Start and Play inputs.
//  - Each physical press produces exactly one Pulse, no matter how much the contact bounces.
// PARAMETERS
//  N_BTN          2    number of button channels (ch0=Start, ch1=Play)
//  DB_CYCLES      16   consecutive stable synced samples needed to accept a press or release (>=2)
//  CNT_W          16   debounce/repeat counter width; must satisfy 2**CNT_W > max(DB_CYCLES,REPEAT_CYCLES)
//  REPEAT_CYCLES  64   auto-repeat period in cycles; used only with BTN_AUTOREPEAT_EN
// PORTS
//  Clk    in   1      system clock
//  Rst    in   1      synchronous, active-high reset
//  BtnIn  in   N_BTN  raw asynchronous button levels, 1 = pressed
//  Pulse  out  N_BTN  one-cycle registered press strobe per channel
//  Level  out  N_BTN  registered debounced button level per channel
// BEHAVIOUR
//  - Reset (Rst=1 at posedge):
//    - sync flops, counters, Pulse and Level all go to 0; every channel goes to IDLE.
//    - Reset mid-press discards all progress. A held button is re-qualified from the start after Rst drops.
//  - Sync: s = BtnIn after 2 flops. All FSM decisions use s only.
//  - Per-channel FSM; the counter clears on every state change:
//    - IDLE: Level=0. s=1 -> PRESS_WAIT with cnt=1.
//    - PRESS_WAIT:
//      - s=0 -> IDLE (bounce rejected, no Pulse).
//      - s=1 with cnt==DB_CYCLES-1 -> PRESSED; Pulse=1 for that one cycle; Level=1.
//      - otherwise cnt++.
//    - PRESSED: Level=1. s=0 -> RELEASE_WAIT with cnt=1.
//    - RELEASE_WAIT: Level stays 1.
//      - s=1 -> PRESSED with no new Pulse (release bounce).
//      - s=0 with cnt==DB_CYCLES-1 -> IDLE; Level=0.
//      - otherwise cnt++.
//  - Latency: BtnIn steady 1 from edge k gives Pulse high exactly in cycle k+2+DB_CYCLES; Level rises in the same cycle.
//  - Release latency is symmetric: Level falls DB_CYCLES+2 cycles after BtnIn steadily returns to 0.
//  - Pulse width is always exactly 1 cycle, and there is at most one Pulse per accepted press.
//  - Channels are fully independent. Simultaneous presses give simultaneous Pulses and do not interact.
//  - Counters saturate and never wrap. A counter wrap is a design error.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//    - In PRESSED, a separate repeat counter runs from the accept cycle.
//    - Every REPEAT_CYCLES cycles while still PRESSED, Pulse fires once more for 1 cycle.
//    - The repeat counter clears on leaving PRESSED.
//    - RELEASE_WAIT pauses the repeat counter (it holds its value); a release bounce back to PRESSED resumes it.
//  BTN_AUTOREPEAT_EN undefined:
//    - No repeat logic. REPEAT_CYCLES is ignored.
//    - Exactly one Pulse per press.
// STRUCTURE
//  - Package btn_pkg:
//    - state encoding constants IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3 (2-bit).
//    - default DB_CYCLES/REPEAT_CYCLES constants for sim and board builds.
//  - Sub-module btn_debounce_ch: one channel (sync, FSM, counters, Pulse/Level regs).
//  - btn_pulse_gen instantiates N_BTN copies of btn_debounce_ch in a generate loop.
// TESTING  (DB_CYCLES=16, REPEAT_CYCLES=64)
//  1. Clean press: BtnIn[0]=1 from edge 10, held 100 cycles -> Pulse[0]=1 only in cycle 28; Level[0]=1 from cycle 28.
//  2. Press bounce: BtnIn[1] toggles every 3 cycles for 30 cycles, then held 1 -> no Pulse during bounce; exactly one Pulse 18 cycles after final rise.
//  3. Release bounce: after an accepted press, BtnIn drops 5 cycles, rises 5, then stays 0 -> no second Pulse; Level falls 18 cycles after the final fall.
//  4. Short glitch: BtnIn=1 for 15 cycles, then 0 -> no Pulse, Level stays 0.
//  5. Reset mid-press: Rst=1 for 1 cycle at PRESS_WAIT cnt=10 with BtnIn still 1 -> outputs 0; Pulse 18 cycles after Rst deasserts.
//  6. BTN_AUTOREPEAT_EN: hold 300 cycles past accept -> Pulses at accept, +64, +128, +192, +256; both channels pressed together pulse in the same cycles.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the push-button conditioning block.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Short windows for simulation, long windows for a ~50 MHz board clock.
  localparam int unsigned DB_CYCLES_SIM      = 16;
  localparam int unsigned REPEAT_CYCLES_SIM  = 64;
  localparam int unsigned DB_CYCLES_BOARD    = 500_000;
  localparam int unsigned REPEAT_CYCLES_BOARD = 12_500_000;

  // True when a CNT_W-bit counter can hold every value the debounce/repeat logic reaches.
  function automatic bit cnt_fits(int unsigned cnt_w, int unsigned db, int unsigned rpt);
    longint unsigned span;
    span = (db > rpt) ? longint'(db) : longint'(rpt);
    return (cnt_w >= 32) || ((64'd1 << cnt_w) > span);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, press one-shot.
// Optional auto-repeat while held is enabled with `define BTN_AUTOREPEAT_EN.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_SIM,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_SIM
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnIn,
  output logic Pulse,
  output logic Level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  if (!cnt_fits(CNT_W, DB_CYCLES, REPEAT_CYCLES)) begin : g_cnt_w_too_small
    $error("btn_debounce_ch: CNT_W too small for DB_CYCLES/REPEAT_CYCLES");
  end

  logic             sync1_q;
  logic             sync2_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // Metastability guard; everything downstream looks only at sync2_q.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= BtnIn;
      sync2_q <= sync1_q;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      Pulse   <= 1'b0;
      Level   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      Pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            Pulse   <= 1'b1;
            Level   <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_W'(1);
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rpt_q == RPT_LAST) begin
            rpt_q <= '0;
            Pulse <= 1'b1;
          end else begin
            rpt_q <= rpt_q + CNT_W'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          // Repeat counter is frozen here so a release bounce resumes the cadence.
          if (sync2_q) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            Level   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// N_BTN independent debounced press-pulse channels (ch0=Start, ch1=Play).
// Define BTN_AUTOREPEAT_EN to make held buttons re-pulse every REPEAT_CYCLES.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = 2,
  parameter int unsigned DB_CYCLES     = DB_CYCLES_SIM,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_SIM
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_BTN-1:0] BtnIn,
  output logic [N_BTN-1:0] Pulse,
  output logic [N_BTN-1:0] Level
);

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .CNT_W        (CNT_W),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .Clk  (Clk),
      .Rst  (Rst),
      .BtnIn(BtnIn[i]),
      .Pulse(Pulse[i]),
      .Level(Level[i])
    );
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen; expected pulse cycles queued per channel.
module tb_btn_pulse_gen;

  localparam int unsigned N_BTN = 2;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [N_BTN-1:0] BtnIn;
  logic [N_BTN-1:0] Pulse;
  logic [N_BTN-1:0] Level;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int q0[$];
  int q1[$];

  btn_pulse_gen #(
    .N_BTN        (N_BTN),
    .DB_CYCLES    (16),
    .CNT_W        (16),
    .REPEAT_CYCLES(64)
  ) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .BtnIn(BtnIn),
    .Pulse(Pulse),
    .Level(Level)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Lands 1 time unit after edge k, where cyc == k.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Monitor: every observed pulse must match the head of its channel's queue.
  always @(negedge Clk) begin
    int e;
    if (Pulse[0]) begin
      e = (q0.size() == 0) ? -1 : q0.pop_front();
      chk("pulse0_cycle", cyc, e);
    end
    if (Pulse[1]) begin
      e = (q1.size() == 0) ? -1 : q1.pop_front();
      chk("pulse1_cycle", cyc, e);
    end
  end

  initial begin
    Rst   = 1'b1;
    BtnIn = '0;
    goto(3);
    Rst = 1'b0;
    chk("reset_pulse", int'(Pulse), 0);
    chk("reset_level", int'(Level), 0);

    // Clean press on ch0
    q0.push_back(28);
`ifdef BTN_AUTOREPEAT_EN
    q0.push_back(92);
`endif
    goto(10);  BtnIn[0] = 1'b1;
    goto(27);  chk("t1_level_pre", int'(Level[0]), 0);
    goto(28);  chk("t1_level_on", int'(Level[0]), 1);
    goto(110); BtnIn[0] = 1'b0;
    goto(127); chk("t1_level_hold", int'(Level[0]), 1);
    goto(128); chk("t1_level_off", int'(Level[0]), 0);

    // Press bounce on ch1: 3-cycle toggles, final rise at 170
    q1.push_back(188);
    for (int i = 0; i < 10; i++) begin
      goto(140 + 3 * i);
      BtnIn[1] = (i % 2 == 0);
    end
    goto(170); BtnIn[1] = 1'b1;
    goto(188); chk("t2_level_on", int'(Level[1]), 1);
    goto(200); BtnIn[1] = 1'b0;
    goto(218); chk("t2_level_off", int'(Level[1]), 0);

    // Release bounce on ch0
    q0.push_back(248);
    goto(230); BtnIn[0] = 1'b1;
    goto(260); BtnIn[0] = 1'b0;
    goto(265); BtnIn[0] = 1'b1;
    goto(270); BtnIn[0] = 1'b0;
    goto(280); chk("t3_level_bounce", int'(Level[0]), 1);
    goto(287); chk("t3_level_hold", int'(Level[0]), 1);
    goto(288); chk("t3_level_off", int'(Level[0]), 0);

    // 15-cycle glitch on ch1 is rejected
    goto(300); BtnIn[1] = 1'b1;
    goto(315); BtnIn[1] = 1'b0;
    goto(320); chk("t4_level_a", int'(Level[1]), 0);
    goto(335); chk("t4_level_b", int'(Level[1]), 0);

    // Reset during PRESS_WAIT (cnt=10) restarts qualification
    goto(340); BtnIn[0] = 1'b1;
    goto(352); Rst = 1'b1;
    goto(353); Rst = 1'b0;
    chk("t5_rst_pulse", int'(Pulse[0]), 0);
    chk("t5_rst_level", int'(Level[0]), 0);
    q0.push_back(371);
    goto(370); chk("t5_level_pre", int'(Level[0]), 0);
    goto(371); chk("t5_level_on", int'(Level[0]), 1);
    goto(380); BtnIn[0] = 1'b0;

    // Simultaneous press on both channels, held 300 cycles past accept
    q0.push_back(438);
    q1.push_back(438);
`ifdef BTN_AUTOREPEAT_EN
    for (int r = 1; r <= 4; r++) begin
      q0.push_back(438 + 64 * r);
      q1.push_back(438 + 64 * r);
    end
`endif
    goto(420); BtnIn = 2'b11;
    goto(438); chk("t6_level_on", int'(Level), 3);
    goto(738); BtnIn = 2'b00;
    goto(755); chk("t6_level_hold", int'(Level), 3);
    goto(756); chk("t6_level_off", int'(Level), 0);

    goto(800);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
